text_buffer_writer: RTL and testbench
=====================================

// Module: text_buffer_writer
// PURPOSE
//  Owns the character grid read by the text pixel renderer (ROWS x COLS cells of
//  8-bit character codes, row-major, cell index = row*COLS + col). Accepts a
//  character stream from the CPU via valid/ready, stores it at a hardware cursor,
//  and handles CR, LF, backspace, line wrap, scroll-up and clear. Sits directly
//  upstream of the renderer; its text array drives the renderer's text input.
// PARAMETERS
//  COLS   64     characters per row
//  ROWS   11     rows; CELLS = COLS*ROWS = 704
//  BLANK  8'h20  code written into cleared or vacated cells
// PORTS
//  clk         in   1       system clock; all logic on posedge
//  rst         in   1       synchronous, active-high reset
//  char_valid  in   1       char_data holds a character to write
//  char_data   in   8       character code or control code
//  char_ready  out  1       combinational: (state==IDLE) && !clear
//  clear       in   1       request full-screen clear; sampled in IDLE only
//  text        out  8 x CELLS  unpacked logic [7:0] text[CELLS-1:0] grid
//  cursor_col  out  $clog2(COLS)  current column, 0..COLS-1
//  cursor_row  out  $clog2(ROWS)  current row, 0..ROWS-1
//  busy        out  1       high in SCROLL or CLEAR
// BEHAVIOUR
//  Reset: every text cell = BLANK in that one edge; cursor = (0,0); state IDLE;
//   busy=0. Reset mid-SCROLL/CLEAR aborts the operation with the same result.
//  Accept: char_valid && char_ready at a posedge. Effect visible on the edge that
//   accepts (text and cursor updated at that edge, zero extra latency).
//  States: IDLE, SCROLL, CLEAR. Index counter idx: 0..CELLS-1.
//  IDLE, clear=1: clear wins over char_valid (char not accepted); idx=0 -> CLEAR.
//  IDLE, accepted code:
//   0x0D CR: col=0; text unchanged.
//   0x0A LF: col=0; row<ROWS-1 -> row+1; row=ROWS-1 -> SCROLL, row stays.
//   0x08 BS: col>0 -> col-1, write BLANK at new cursor; col=0,row>0 -> (row-1,
//     COLS-1), write BLANK there; at (0,0) no-op.
//   other codes: text[cursor]=char_data; col<COLS-1 -> col+1; col=COLS-1 ->
//     col=0 and row+1, or SCROLL if row=ROWS-1 (row stays ROWS-1).
//  SCROLL: one cell per cycle, idx 0..CELLS-1: idx<CELLS-COLS ->
//   text[idx]=text[idx+COLS], else text[idx]=BLANK. After idx=CELLS-1 -> IDLE,
//   cursor=(ROWS-1,0). Duration exactly CELLS cycles with busy=1, char_ready=0.
//  CLEAR: text[idx]=BLANK per cycle, idx 0..CELLS-1, then IDLE, cursor=(0,0).
//   CELLS cycles, busy=1, char_ready=0.
//  clear or char_valid asserted while busy: ignored (not latched); the producer
//   holds char_valid until char_ready per the handshake rule.
//  char_valid held with data stable is required of producer; data may change
//   only after acceptance. Cursor never leaves 0..ROWS-1 x 0..COLS-1.
//  Renderer reads text combinationally; cells change only on the edges above.
// TESTING
//  1 Reset: rst=1 one cycle -> all 704 cells 0x20, cursor (0,0), char_ready=1.
//  2 Write "AB" -> text[0]=0x41, text[1]=0x42, cursor (0,2), one char/cycle.
//  3 Wrap: 64 x 'X' from (0,0) -> cells 0..63 = 0x58, cursor (1,0); then BS ->
//    cursor (0,63), text[63]=0x20.
//  4 Scroll: cursor (10,63), write 'Z' -> busy for exactly 704 cycles, row9 col63
//    =0x5A, row10 all 0x20, row0 = former row1, cursor (10,0), char_ready back 1.
//  5 Clear vs char: clear=1 and char_valid=1 same cycle in IDLE -> char not taken,
//    704 busy cycles, all 0x20, cursor (0,0); held char then accepted at (0,0).
//  6 rst pulse at SCROLL idx=300 -> next cycle all cells 0x20, IDLE, cursor (0,0).

Source files
------------

// File: rtl/text_buffer_writer.sv
// -----------------------------------------------------------------------------
// text_buffer_writer
//
// Owns the character grid that the text pixel renderer reads. The grid has
// ROWS x COLS cells of 8-bit character codes. Cells are stored row-major, so
// cell index = row*COLS + col.
//
// A CPU-side producer streams characters into the block. Each character is
// stored at a hardware cursor. The block also handles these control codes:
//   CR (0x0D)  - carriage return
//   LF (0x0A)  - line feed
//   BS (0x08)  - backspace
// It also handles line wrap, scroll-up by one row, and a full-screen clear.
//
// Handshake: a character is accepted on any posedge where char_valid and
// char_ready are both high. char_ready is combinational and is high only in
// IDLE with no clear request pending. The accepting edge also updates the text
// and the cursor, so there is no extra latency. The producer must keep
// char_valid and char_data stable until acceptance. A clear request is honoured
// only in IDLE, and it takes priority over a pending character.
//
// Ports
//   clk         in   system clock, all logic on posedge
//   rst         in   synchronous active-high reset
//   char_valid  in   char_data holds a character or control code
//   char_data   in   8-bit character / control code
//   char_ready  out  block can take a character this cycle
//   clear       in   full-screen clear request (IDLE only)
//   text        out  unpacked grid, text[CELLS-1:0], read by the renderer
//   cursor_col  out  current column, 0..COLS-1
//   cursor_row  out  current row, 0..ROWS-1
//   busy        out  high while a scroll or clear sweep is running
//   state_dbg   out  current FSM state (IDLE=0, SCROLL=1, CLEAR=2)
// -----------------------------------------------------------------------------
module text_buffer_writer #(
  parameter int         COLS  = 64,
  parameter int         ROWS  = 11,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      char_valid,
  input  logic [7:0]                char_data,
  output logic                      char_ready,
  input  logic                      clear,
  output logic [7:0]                text [COLS*ROWS-1:0],
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic                      busy,
  output logic [1:0]                state_dbg
);

  localparam int CELLS = COLS * ROWS;
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int IW    = $clog2(CELLS);

  localparam logic [7:0] CODE_CR = 8'h0D;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_BS = 8'h08;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    CLEAR  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [CW-1:0]   col_n;
  logic [RW-1:0]   row_n;

  // A single write port into the grid is enough. Each state writes at most
  // one cell per cycle.
  logic            wr_en;
  logic [IW-1:0]   wr_addr;
  logic [7:0]      wr_data;

  logic [IW-1:0]   cur_idx;
  logic [IW-1:0]   src_idx;
  logic            idx_last;
  logic            row_last;
  logic            col_last;

  assign cur_idx  = IW'(cursor_row) * IW'(COLS) + IW'(cursor_col);
  assign idx_last = (idx == IW'(CELLS - 1));
  assign row_last = (cursor_row == RW'(ROWS - 1));
  assign col_last = (cursor_col == CW'(COLS - 1));

  // During a scroll, the cell one row below is copied up. In the last row
  // there is nothing below, so the address is held in range and the copy is
  // replaced by BLANK.
  assign src_idx = (idx < IW'(CELLS - COLS)) ? (idx + IW'(COLS)) : idx;

  assign char_ready = (state == IDLE) && !clear;
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    col_n   = cursor_col;
    row_n   = cursor_row;
    wr_en   = 1'b0;
    wr_addr = idx;
    wr_data = BLANK;

    case (state)
      IDLE: begin
        if (clear) begin
          idx_n   = '0;
          state_n = CLEAR;
        end else if (char_valid) begin
          case (char_data)
            CODE_CR: begin
              col_n = '0;
            end
            CODE_LF: begin
              col_n = '0;
              if (!row_last) begin
                row_n = cursor_row + RW'(1);
              end else begin
                idx_n   = '0;
                state_n = SCROLL;
              end
            end
            CODE_BS: begin
              // In both cases below, the new cursor is the cell just before
              // the current one in row-major order.
              if (cursor_col != '0) begin
                col_n   = cursor_col - CW'(1);
                wr_en   = 1'b1;
                wr_addr = cur_idx - IW'(1);
              end else if (cursor_row != '0) begin
                row_n   = cursor_row - RW'(1);
                col_n   = CW'(COLS - 1);
                wr_en   = 1'b1;
                wr_addr = cur_idx - IW'(1);
              end
            end
            default: begin
              wr_en   = 1'b1;
              wr_addr = cur_idx;
              wr_data = char_data;
              if (!col_last) begin
                col_n = cursor_col + CW'(1);
              end else begin
                col_n = '0;
                if (!row_last) begin
                  row_n = cursor_row + RW'(1);
                end else begin
                  idx_n   = '0;
                  state_n = SCROLL;
                end
              end
            end
          endcase
        end
      end

      SCROLL: begin
        wr_en   = 1'b1;
        wr_addr = idx;
        wr_data = (idx < IW'(CELLS - COLS)) ? text[src_idx] : BLANK;
        if (idx_last) begin
          state_n = IDLE;
          row_n   = RW'(ROWS - 1);
          col_n   = '0;
        end else begin
          idx_n = idx + IW'(1);
        end
      end

      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = idx;
        wr_data = BLANK;
        if (idx_last) begin
          state_n = IDLE;
          row_n   = '0;
          col_n   = '0;
        end else begin
          idx_n = idx + IW'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cursor_col <= col_n;
      cursor_row <= row_n;
    end
  end

  // Reset blanks the whole grid in one edge. This also aborts any sweep that
  // is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) begin
        text[i] <= BLANK;
      end
    end else if (wr_en) begin
      text[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_text_buffer_writer.sv
module tb_text_buffer_writer;
  localparam int         COLS  = 64;
  localparam int         ROWS  = 11;
  localparam int         CELLS = COLS * ROWS;
  localparam logic [7:0] BLANK = 8'h20;
  localparam int         BOUND = 2000;

  // clock / reset / DUT signals
  logic       clk = 1'b0;
  logic       rst;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic       clear;
  logic [7:0] text [CELLS-1:0];
  logic [5:0] cursor_col;
  logic [3:0] cursor_row;
  logic       busy;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  text_buffer_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .clear      (clear),
    .text       (text),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard entry: {check_cell, addr[9:0], value[7:0], row[3:0], col[5:0]}
  logic [28:0] exp_q[$];
  logic [28:0] item;
  logic        acc = 1'b0;

  // reference model: a 2-D screen with a cursor
  logic [7:0] m [ROWS][COLS];
  int         mr, mc;

  task automatic model_blank();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m[r][c] = BLANK;
    mr = 0;
    mc = 0;
  endtask

  task automatic model_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) m[r][c] = m[r+1][c];
    for (int c = 0; c < COLS; c++) m[ROWS-1][c] = BLANK;
    mr = ROWS - 1;
    mc = 0;
  endtask

  task automatic model_char(input logic [7:0] ch, output bit scr, output bit chk,
                            output int addr, output logic [7:0] val);
    scr = 0; chk = 0; addr = 0; val = 8'h00;
    case (ch)
      8'h0D: mc = 0;
      8'h0A: begin
        mc = 0;
        if (mr < ROWS - 1) mr++;
        else scr = 1;
      end
      8'h08: begin
        if (mc > 0) begin
          mc--;
          m[mr][mc] = BLANK; chk = 1; addr = mr * COLS + mc; val = BLANK;
        end else if (mr > 0) begin
          mr--; mc = COLS - 1;
          m[mr][mc] = BLANK; chk = 1; addr = mr * COLS + mc; val = BLANK;
        end
      end
      default: begin
        m[mr][mc] = ch; chk = 1; addr = mr * COLS + mc; val = ch;
        if (mc < COLS - 1) mc++;
        else begin
          mc = 0;
          if (mr < ROWS - 1) mr++;
          else scr = 1;
        end
      end
    endcase
  endtask

  // monitor: checks every accepted character against the scoreboard
  always @(posedge clk) acc <= char_valid && char_ready && !rst;

  always @(negedge clk) begin
    if (acc) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_accept: DUT took a character, none expected");
      end else begin
        item = exp_q.pop_front();
        if ({cursor_row, cursor_col} != item[9:0]) begin
          errors++;
          $display("FAIL accept_cursor: got (%0d,%0d) expected (%0d,%0d)",
                   cursor_row, cursor_col, item[9:6], item[5:0]);
        end
        if (item[28]) begin
          checks++;
          if (text[item[27:18]] != item[17:10]) begin
            errors++;
            $display("FAIL accept_cell[%0d]: got %h expected %h",
                     item[27:18], text[item[27:18]], item[17:10]);
          end
        end
      end
    end
  end

  // checks against the model, called at a negedge
  task automatic compare_grid(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < CELLS; i++) begin
      if (text[i] !== m[i / COLS][i % COLS]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d cells differ, first cell %0d got %h expected %h",
               name, bad, first, text[first], m[first / COLS][first % COLS]);
    end
  endtask

  task automatic check_cursor(input string name);
    checks++;
    if (cursor_row !== 4'(mr) || cursor_col !== 6'(mc)) begin
      errors++;
      $display("FAIL %s: cursor got (%0d,%0d) expected (%0d,%0d)",
               name, cursor_row, cursor_col, mr, mc);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic wait_sweep(input string name);
    int n = 0;
    while (busy && n < BOUND) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != CELLS) begin
      errors++;
      $display("FAIL %s: busy lasted %0d cycles expected %0d", name, n, CELLS);
    end
  endtask

  // driver: valid is already high with data stable; the next posedge accepts
  task automatic accept_now(input logic [7:0] ch, input bit wait_scroll);
    bit scr, chk;
    int addr;
    logic [7:0] val;
    @(posedge clk);
    model_char(ch, scr, chk, addr, val);
    exp_q.push_back({chk, 10'(addr), val, 4'(mr), 6'(mc)});
    if (scr) begin
      model_scroll();
      @(negedge clk);
      char_valid = 1'b0;
      if (wait_scroll) begin
        wait_sweep("scroll_busy_len");
        compare_grid("scroll_grid");
        check_cursor("scroll_cursor");
        check_bit("scroll_ready_back", char_ready, 1'b1);
      end
    end
  endtask

  task automatic put(input logic [7:0] ch, input bit wait_scroll);
    int n = 0;
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = ch;
    while (!char_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) begin
      checks++;
      errors++;
      $display("FAIL put_timeout: char_ready low for %0d cycles", n);
      char_valid = 1'b0;
    end else begin
      accept_now(ch, wait_scroll);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic goto_last_cell();
    put(8'h0D, 1);
    for (int i = 0; i < ROWS; i++) put(8'h0A, 1);
    for (int i = 0; i < COLS - 1; i++) put(8'h61 + 8'(i % 26), 1);
  endtask

  initial begin
    rst = 1'b1; char_valid = 1'b0; char_data = 8'h00; clear = 1'b0;
    model_blank();
    @(negedge clk);
    rst = 1'b0;

    // 1 reset state
    compare_grid("reset_grid");
    check_cursor("reset_cursor");
    check_bit("reset_ready", char_ready, 1'b1);
    check_bit("reset_busy", busy, 1'b0);

    // 2 "AB", one character per cycle
    put(8'h41, 1);
    put(8'h42, 1);
    idle();
    compare_grid("ab_grid");

    // 3 wrap of a full row, then backspace across the wrap
    put(8'h0D, 1);
    for (int i = 0; i < COLS; i++) put(8'h58, 1);
    put(8'h08, 1);
    idle();
    compare_grid("wrap_bs_grid");
    check_cursor("wrap_bs_cursor");

    // 4 scroll triggered by a printable character at the last cell
    goto_last_cell();
    put(8'h5A, 1);
    compare_grid("scroll_z_grid");

    // 5 clear and char together: clear wins, held char lands at (0,0)
    idle();
    clear = 1'b1; char_valid = 1'b1; char_data = 8'h51;
    @(posedge clk);
    model_blank();
    @(negedge clk);
    clear = 1'b0;
    wait_sweep("clear_busy_len");
    compare_grid("clear_grid");
    check_bit("clear_ready_back", char_ready, 1'b1);
    accept_now(8'h51, 1);
    idle();
    compare_grid("clear_q_grid");

    // 6 reset in the middle of a scroll
    goto_last_cell();
    put(8'h0A, 0);
    repeat (300) @(negedge clk);
    check_bit("mid_scroll_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_blank();
    compare_grid("abort_grid");
    check_cursor("abort_cursor");
    check_bit("abort_busy", busy, 1'b0);

    // random stream
    for (int k = 0; k < 300; k++) begin
      int r;
      logic [7:0] ch;
      if ($urandom_range(0, 7) == 0) begin
        idle();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      r = $urandom_range(0, 99);
      if (r < 8) ch = 8'h0D;
      else if (r < 18) ch = 8'h0A;
      else if (r < 30) ch = 8'h08;
      else ch = 8'($urandom_range(33, 126));
      put(ch, 1);
    end
    idle();
    compare_grid("random_grid");
    check_cursor("random_cursor");

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected accepts never seen", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
